johnson_seq_ctrl: RTL and testbench

//  Controller that sequences a WIDTH-bit Johnson (twisted-ring) counter for phase generation.

---
 rtl/johnson_seq_ctrl_pkg.sv | 44 ++++
 rtl/johnson_seq_ctrl_if.sv | 30 +++
 rtl/johnson_seq_ctrl_ring.sv | 34 +++
 rtl/johnson_seq_ctrl.sv | 117 +++++++++++
 tb/tb_johnson_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared types and helpers for the Johnson ring sequencer.
// Code helpers take a 32-bit code plus its live width.
package johnson_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Legal codes are thermometers: at most one bit-to-bit transition.
    function automatic logic johnson_is_legal(
        input logic [31:0] code,
        input int unsigned w
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if (i + 1 < int'(w) && code[5'(i)] != code[5'(i + 1)])
                n++;
        end
        return n <= 32'd1;
    endfunction

    function automatic int unsigned johnson_idx(
        input logic [31:0] code,
        input int unsigned w
    );
        int unsigned pop;
        logic [4:0]  top;
        pop = 0;
        top = 5'(w - 1);
        for (int i = 0; i < 32; i++) begin
            if (i < int'(w) && code[5'(i)])
                pop++;
        end
        return code[top] ? 2 * w - pop : pop;
    endfunction

endpackage

// File: rtl/johnson_seq_ctrl_if.sv
// Control/status bundle between system control and the sequencer.
// master drives requests, slave is the sequencer.
interface johnson_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int IW    = $clog2(2 * WIDTH)
);
    logic             start;
    logic [CNT_W-1:0] step_count;
    logic             dir;
    logic             hold;
    logic             abort;
    logic             err_clr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] phase;
    logic [IW-1:0]    phase_idx;
    logic             wrap;
    logic             err;

    modport master (
        output start, step_count, dir, hold, abort, err_clr,
        input  busy, done, phase, phase_idx, wrap, err
    );

    modport slave (
        input  start, step_count, dir, hold, abort, err_clr,
        output busy, done, phase, phase_idx, wrap, err
    );
endinterface

// File: rtl/johnson_seq_ctrl_ring.sv
// Twisted-ring register with step/direction and synchronous clear.
// o_next exposes the code one step ahead so the owner can spot wraps.
module johnson_ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_step_en,
    input  logic             i_dir,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_phase,
    output logic [WIDTH-1:0] o_next
);
    import johnson_seq_pkg::*;

    logic [WIDTH-1:0] r_phase;

    always_comb begin
        o_next = {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
        if (i_dir == DIR_REV)
            o_next = {~r_phase[0], r_phase[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_phase <= '0;
        else if (i_clr)
            r_phase <= '0;
        else if (i_step_en)
            r_phase <= o_next;
    end

    assign o_phase = r_phase;
endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer: run/hold/abort FSM, step counter,
// illegal-code scrubbing with sticky error, and wrap pulse.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    johnson_seq_if.slave bus
);
    import johnson_seq_pkg::*;

    localparam int IW = $clog2(2 * WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_rem;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_ring;
    logic [WIDTH-1:0] w_phase;
    logic [WIDTH-1:0] w_next;
    logic             w_illegal;
    logic             w_active;
    logic             w_step;
    logic             w_clr;

    assign w_phase   = w_ring;
    assign w_illegal = !johnson_is_legal(32'(w_phase), WIDTH);
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign w_step    = !w_illegal && (r_state == ST_RUN)
                       && !bus.abort && !bus.hold;
    assign w_clr     = w_illegal || (w_active && bus.abort);

    johnson_ring #(.WIDTH(WIDTH)) u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_step_en (w_step),
        .i_dir     (r_dir),
        .i_clr     (w_clr),
        .o_phase   (w_ring),
        .o_next    (w_next)
    );

    // A scrub cycle freezes the FSM so no step is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_dir   <= DIR_FWD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!w_illegal) begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dir <= bus.dir;
                        r_rem <= bus.step_count;
                        if (bus.step_count != '0) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.hold) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == 1) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!bus.hold) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_err  <= w_illegal | (r_err & ~bus.err_clr);
            r_wrap <= w_step && (w_next == '0);
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.phase     = w_phase;
    assign bus.phase_idx = IW'(johnson_idx(32'(w_phase), WIDTH));
    assign bus.wrap      = r_wrap;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: position-based reference model
// compared every cycle, plus directed literal expectations.
module tb_johnson_seq_ctrl;

    logic clk;
    logic reset_n;
    bit   chk_on;
    bit   inj;
    int   errors;
    int   checks;

    johnson_seq_if #(.WIDTH(4), .CNT_W(8)) io ();

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ring tracked as a position 0..7 on the 8-state cycle.
    int m_st;
    int m_pos;
    int m_rem;
    bit m_dir;
    bit m_err;
    bit m_wrap;

    function automatic int nxt(input int p, input bit d);
        return d ? (p + 7) % 8 : (p + 1) % 8;
    endfunction

    function automatic int code_of(input int p);
        if (p <= 4)
            return (1 << p) - 1;
        return 15 & ~((1 << (p - 4)) - 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st   <= 0;
            m_pos  <= 0;
            m_rem  <= 0;
            m_dir  <= 1'b0;
            m_err  <= 1'b0;
            m_wrap <= 1'b0;
        end else begin
            m_wrap <= 1'b0;
            m_err  <= inj ? 1'b1 : (io.err_clr ? 1'b0 : m_err);
            if (inj) begin
                m_pos <= 0;
            end else begin
                case (m_st)
                    0: if (io.start) begin
                        m_dir <= io.dir;
                        m_rem <= int'(io.step_count);
                        m_st  <= (io.step_count == 0) ? 3 : 1;
                    end
                    1: if (io.abort) begin
                        m_st  <= 0;
                        m_pos <= 0;
                    end else if (io.hold) begin
                        m_st <= 2;
                    end else begin
                        m_pos  <= nxt(m_pos, m_dir);
                        m_wrap <= (nxt(m_pos, m_dir) == 0);
                        m_rem  <= m_rem - 1;
                        if (m_rem == 1)
                            m_st <= 3;
                    end
                    2: if (io.abort) begin
                        m_st  <= 0;
                        m_pos <= 0;
                    end else if (!io.hold) begin
                        m_st <= 1;
                    end
                    default: m_st <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            chk("busy", int'(io.busy), int'(m_st == 1 || m_st == 2));
            chk("done", int'(io.done), int'(m_st == 3));
            chk("phase", int'(io.phase), code_of(m_pos));
            chk("phase_idx", int'(io.phase_idx), m_pos);
            chk("wrap", int'(io.wrap), int'(m_wrap));
            chk("err", int'(io.err), int'(m_err));
        end
    end

    // Launch a run and watch it to completion; *_k pick the sample
    // index after which a hold/abort/inject/extra start is applied.
    task automatic run(
        input  int cnt,
        input  bit d,
        input  int hold_k,
        input  int hold_n,
        input  int abort_k,
        input  int inj_k,
        input  int start_k,
        output int nb,
        output int nd,
        output int nw
    );
        bit fin;
        fin = 1'b0;
        nb  = 0;
        nd  = 0;
        nw  = 0;
        io.start      = 1'b1;
        io.step_count = 8'(cnt);
        io.dir        = d;
        @(negedge clk);
        io.start      = 1'b0;
        io.step_count = 8'd2;
        io.dir        = ~d;
        for (int k = 0; k < 100 && !fin; k++) begin
            nb += int'(io.busy);
            nd += int'(io.done);
            nw += int'(io.wrap);
            if (!io.busy && !io.done) begin
                fin = 1'b1;
            end else begin
                io.hold  = (k >= hold_k && k < hold_k + hold_n);
                io.abort = (k == abort_k);
                io.start = (k == abort_k || k == start_k);
                if (k == inj_k) begin
                    #1;
                    inj = 1'b1;
                    force dut.w_phase = 4'b0101;
                    @(posedge clk);
                    #1;
                    release dut.w_phase;
                    inj = 1'b0;
                end
                @(negedge clk);
                if (k == inj_k) begin
                    chk("inj_err", int'(io.err), 1);
                    chk("inj_phase", int'(io.phase), 0);
                end
            end
        end
        io.hold  = 1'b0;
        io.abort = 1'b0;
        io.start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got busy=%0d, expected idle",
                     io.busy);
        end
    endtask

    int nb;
    int nd;
    int nw;

    initial begin
        errors        = 0;
        checks        = 0;
        chk_on        = 1'b0;
        inj           = 1'b0;
        reset_n       = 1'b0;
        io.start      = 1'b0;
        io.step_count = 8'd0;
        io.dir        = 1'b0;
        io.hold       = 1'b0;
        io.abort      = 1'b0;
        io.err_clr    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(io.busy), 0);
        chk("rst_done", int'(io.done), 0);
        chk("rst_phase", int'(io.phase), 0);
        chk("rst_idx", int'(io.phase_idx), 0);
        chk("rst_wrap", int'(io.wrap), 0);
        chk("rst_err", int'(io.err), 0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        @(negedge clk);

        run(5, 1'b0, -1, 0, -1, -1, -1, nb, nd, nw);
        chk("t1_busy_cycles", nb, 5);
        chk("t1_done_pulses", nd, 1);
        chk("t1_phase", int'(io.phase), 4'b1110);
        chk("t1_idx", int'(io.phase_idx), 5);

        run(3, 1'b1, -1, 0, -1, -1, -1, nb, nd, nw);
        chk("t2_phase", int'(io.phase), 4'b0011);
        chk("t2_idx", int'(io.phase_idx), 2);
        chk("t2_no_wrap", nw, 0);
        run(2, 1'b1, -1, 0, -1, -1, -1, nb, nd, nw);
        chk("t2_to_zero_wrap", nw, 1);
        run(10, 1'b0, -1, 0, -1, -1, -1, nb, nd, nw);
        chk("t2_wrap_once", nw, 1);
        chk("t2_phase10", int'(io.phase), 4'b0011);
        run(2, 1'b1, -1, 0, -1, -1, -1, nb, nd, nw);

        run(6, 1'b0, 1, 2, -1, -1, -1, nb, nd, nw);
        chk("t3_busy_cycles", nb, 9);
        chk("t3_phase", int'(io.phase), 4'b1100);
        chk("t3_idx", int'(io.phase_idx), 6);

        run(7, 1'b0, -1, 0, 2, -1, -1, nb, nd, nw);
        chk("t4_no_done", nd, 0);
        chk("t4_phase", int'(io.phase), 0);
        @(negedge clk);
        chk("t4_start_ignored", int'(io.busy), 0);

        run(6, 1'b0, -1, 0, -1, 2, -1, nb, nd, nw);
        chk("t5_done", nd, 1);
        chk("t5_phase", int'(io.phase), 4'b1111);
        chk("t5_err_sticky", int'(io.err), 1);
        io.err_clr = 1'b1;
        @(negedge clk);
        io.err_clr = 1'b0;
        chk("t5_err_clr", int'(io.err), 0);

        run(5, 1'b0, -1, 0, -1, -1, 1, nb, nd, nw);
        chk("t6_busy_cycles", nb, 5);
        chk("t6_phase", int'(io.phase), 4'b0001);
        run(0, 1'b0, -1, 0, -1, -1, -1, nb, nd, nw);
        chk("t6_zero_done", nd, 1);
        chk("t6_zero_busy", nb, 0);
        chk("t6_zero_phase", int'(io.phase), 4'b0001);

        io.start      = 1'b1;
        io.step_count = 8'd5;
        io.dir        = 1'b0;
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", int'(io.busy), 0);
        chk("arst_done", int'(io.done), 0);
        chk("arst_phase", int'(io.phase), 0);
        chk("arst_idx", int'(io.phase_idx), 0);
        chk("arst_wrap", int'(io.wrap), 0);
        chk("arst_err", int'(io.err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
